hub75_scan_ctrl: RTL
====================

HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 64: columns shifted per scan row; must be at least 2.
REQ-002 Parameter ROW_ADDR_W, default 4: scan row address width, giving 2**ROW_ADDR_W scan rows.
REQ-003 Parameter DEPTH, default 4: colour bits per channel, equal to the number of bit planes.
REQ-004 Parameter BASE_T, default 8: display time of plane 0, in clk cycles.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous and active-low.
REQ-007 en  in  1  scan enable.
REQ-008 swap_req  in  1  level request to flip the display buffer; held until swap_ack.
REQ-009 swap_ack  out  1  one-cycle pulse; the swap has occurred.
REQ-010 buf_sel  out  1  buffer currently displayed.
REQ-011 px_rd  out  1  pixel read strobe.
REQ-012 px_row  out  ROW_ADDR_W  scan row being read.
REQ-013 px_col  out  clog2(COLS)  column being read.
REQ-014 px_top  in  3*DEPTH  upper-half pixel {R,G,B}; valid exactly 1 cycle after px_rd.
REQ-015 px_bot  in  3*DEPTH  lower-half pixel {R,G,B}; same timing as px_top.
REQ-016 row_addr  out  ROW_ADDR_W  panel row lines (A,B,C,D...).
REQ-017 R0,G0,B0,R1,G1,B1  out  1 each  panel serial colour data.
REQ-018 clk_shft  out  1  panel shift clock; the panel samples on its rising edge.
REQ-019 LAT  out  1  latch pulse, active high.
REQ-020 OE  out  1  output enable, active low.

Function
REQ-021 The FSM SHALL have four states: IDLE, SHIFT, LATCH, DISPLAY. Counters: row r, plane p, column c, display timer.
REQ-022 IDLE SHALL hold OE=1 and clk_shft=0. When en=1 it SHALL go to SHIFT next cycle with r=0 and p=0.
REQ-023 SHIFT SHALL last exactly 2*COLS+1 cycles, numbered s=0..2*COLS.
- s=0: px_rd=1, px_col=0.
- s=2k+1: colour lines = bit p of column k, clk_shft=0, px_rd=1 for column k+1 when k<COLS-1.
- s=2k+2: clk_shft=1, data held.
REQ-024 Colour bit select: R0=px_top[2*DEPTH+p], G0=px_top[DEPTH+p], B0=px_top[p]. R1, G1, B1 use px_bot the same way.
REQ-025 px_row SHALL equal r throughout SHIFT. The pixel source SHALL use buf_sel as its buffer index.
REQ-026 OE SHALL be 1 for all of SHIFT and LATCH.
REQ-027 LATCH SHALL last 1 cycle: LAT=1, clk_shft=0, and row_addr loaded with r in that cycle.
REQ-028 DISPLAY SHALL drive OE=0 for exactly BASE_T<<p cycles, then advance:
- p increments;
- on p wrap (DEPTH-1 to 0), r increments;
- on r wrap (2**ROW_ADDR_W-1 to 0), the frame ends.
REQ-029 After DISPLAY the FSM SHALL go to SHIFT on the next cycle if en=1, else to IDLE. There are no idle gap cycles.
REQ-030 At frame end with swap_req=1, including swap_req rising in that same cycle:
- buf_sel SHALL toggle;
- swap_ack SHALL pulse for exactly 1 cycle, coincident with the first cycle of the next frame or IDLE.
REQ-031 swap_req seen mid-frame SHALL be deferred to the frame end; buf_sel SHALL never change mid-frame.
REQ-032 swap_req held high after swap_ack SHALL cause a new swap at every frame end.
REQ-033 en deasserted mid-frame SHALL NOT abort the current plane; it takes effect at the end of that DISPLAY.
REQ-034 Re-enabling from IDLE SHALL restart the frame at r=0, p=0.
REQ-035 Scan timing is fixed: plane period = 2*COLS+2+(BASE_T<<p) cycles; frame = 2**ROW_ADDR_W times the sum of plane periods over p.
REQ-036 Counters SHALL be wide enough that BASE_T<<(DEPTH-1) cannot overflow.

Reset
REQ-037 When rst=0 at a clock edge, the next cycle SHALL have:
- state IDLE;
- OE=1, LAT=0, clk_shft=0;
- R0..B1=0, row_addr=0, px_rd=0, px_row=0, px_col=0;
- buf_sel=0, swap_ack=0;
- r, p, c and the timer cleared.
REQ-038 Reset asserted mid-operation (SHIFT, LATCH or DISPLAY) SHALL give the same result, with no pending swap retained.

Verification (COLS=4, ROW_ADDR_W=1, DEPTH=2, BASE_T=4)
REQ-039 Reset, then en=1 -> first px_rd one cycle after leaving IDLE. Frame length = 64 cycles. Per row: OE low runs of 4 and 8 cycles, 1 LAT pulse per plane, 8 clk_shft rising edges per row.
REQ-040 px_top=6'b10_01_11 for all columns -> plane 0 shifts R0=0, G0=1, B0=1; plane 1 shifts R0=1, G0=0, B0=1. Each value is stable across its clk_shft rising edge.
REQ-041 swap_req raised at cycle 10 of a frame -> buf_sel and swap_ack are unchanged until the frame boundary; then buf_sel=1 and swap_ack is high for 1 cycle. With swap_req held high, buf_sel=0 at the following boundary.
REQ-042 en dropped during row 1 SHIFT of plane 0 -> LATCH and a 4-cycle OE=0 still occur, then IDLE with OE=1. Re-enabling gives row_addr=0 at the next LATCH.
REQ-043 rst=0 during DISPLAY with swap_req=1 -> all REQ-037 values next cycle, buf_sel=0, and no swap_ack.
REQ-044 Across all scenarios, row_addr SHALL change only in cycles where OE=1.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scan controller: per scan row and bit plane it shifts one row of
// pixel bits, latches them, then lights the row for a binary-weighted time.
module hub75_scan_ctrl #(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 4,
  parameter int DEPTH      = 4,
  parameter int BASE_T     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      buf_sel,
  output logic                      px_rd,
  output logic [ROW_ADDR_W-1:0]     px_row,
  output logic [$clog2(COLS)-1:0]   px_col,
  input  logic [3*DEPTH-1:0]        px_top,
  input  logic [3*DEPTH-1:0]        px_bot,
  output logic [ROW_ADDR_W-1:0]     row_addr,
  output logic                      R0,
  output logic                      G0,
  output logic                      B0,
  output logic                      R1,
  output logic                      G1,
  output logic                      B1,
  output logic                      clk_shft,
  output logic                      LAT,
  output logic                      OE
);

  localparam int COL_W = $clog2(COLS);
  localparam int S_W   = $clog2(2*COLS + 1);
  localparam int T_W   = $clog2((BASE_T << (DEPTH-1)) + 1);
  localparam int P_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [S_W-1:0] S_LAST    = S_W'(2*COLS);
  localparam logic [S_W-1:0] S_LAST_RD = S_W'(2*COLS - 1);
  localparam logic [P_W-1:0] P_LAST    = P_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t                state, next;
  logic [S_W-1:0]        s;
  logic [T_W-1:0]        tmr;
  logic [T_W-1:0]        t_len;
  logic [P_W-1:0]        p;
  logic [ROW_ADDR_W-1:0] r;
  logic [5:0]            col_q;
  logic [2:0]            live_top, live_bot;
  logic                  shift_end, disp_end, p_wrap, r_wrap, frame_end;

  function automatic logic [2:0] plane_bits(input logic [3*DEPTH-1:0] px,
                                            input logic [P_W-1:0]     pl);
    logic [DEPTH-1:0] rc, gc, bc;
    {rc, gc, bc} = px;
    return {rc[pl], gc[pl], bc[pl]};
  endfunction

  assign t_len     = T_W'(BASE_T) << p;
  assign shift_end = (state == SHIFT) && (s == S_LAST);
  assign disp_end  = (state == DISPLAY) && (tmr == t_len - 1'b1);
  assign p_wrap    = (p == P_LAST);
  assign r_wrap    = (r == '1);
  assign frame_end = disp_end && p_wrap && r_wrap;
  assign live_top  = plane_bits(px_top, p);
  assign live_bot  = plane_bits(px_bot, p);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (en) next = SHIFT;
      SHIFT:   if (shift_end) next = LATCH;
      LATCH:   next = DISPLAY;
      DISPLAY: if (disp_end) next = en ? SHIFT : IDLE;
      default: next = IDLE;
    endcase
  end

  // Counters, row address, buffer swap and held colour bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      s        <= '0;
      tmr      <= '0;
      p        <= '0;
      r        <= '0;
      row_addr <= '0;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
      col_q    <= '0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE: begin
          s   <= '0;
          tmr <= '0;
          p   <= '0;
          r   <= '0;
        end
        SHIFT: begin
          s <= shift_end ? '0 : s + 1'b1;
          // Row lines move on entry to LATCH so they never change while lit
          if (shift_end) row_addr <= r;
          if (s[0]) col_q <= {live_top, live_bot};
        end
        LATCH: tmr <= '0;
        DISPLAY: begin
          if (disp_end) begin
            tmr <= '0;
            p   <= p_wrap ? '0 : p + 1'b1;
            if (p_wrap) r <= r + 1'b1;
            // swap_req is a held level, so sampling it only here defers it to frame end
            if (frame_end && swap_req) begin
              buf_sel  <= ~buf_sel;
              swap_ack <= 1'b1;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    px_rd    = 1'b0;
    px_col   = '0;
    px_row   = '0;
    clk_shft = 1'b0;
    LAT      = (state == LATCH);
    OE       = (state != DISPLAY);
    {R0, G0, B0, R1, G1, B1} = col_q;
    if (state == SHIFT) begin
      px_rd    = (s == '0) || (s[0] && (s < S_LAST_RD));
      px_col   = COL_W'((s + 1'b1) >> 1);
      px_row   = r;
      clk_shft = !s[0] && (s != '0);
      // Odd steps present the freshly read pixel; even steps hold it across the shift edge
      if (s[0]) {R0, G0, B0, R1, G1, B1} = {live_top, live_bot};
    end
  end

endmodule
